if_id_buf: RTL and testbench
============================

IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of buffered instruction entries; legal values are 2 and 4.
REQ-002 SHALL have port clk  input  1  core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 SHALL have port inst_i  input  INST_DATA_WIDTH(32)  fetched instruction word.
REQ-005 SHALL have port inst_addr_i  input  INST_ADDR_WIDTH(32)  address of inst_i.
REQ-006 SHALL have port inst_valid_i  input  1  fetch presents a valid instruction.
REQ-007 SHALL have port inst_ready_o  output  1  buffer accepts an instruction this cycle.
REQ-008 SHALL have port jump_flag_i  input  1  redirect from ex; flush all buffered instructions.
REQ-009 SHALL have port hold_flag_i  input  1  decode stall; head entry not consumed.
REQ-010 SHALL have port inst_o  output  INST_DATA_WIDTH(32)  head instruction to id.
REQ-011 SHALL have port inst_addr_o  output  INST_ADDR_WIDTH(32)  head instruction address to id.
REQ-012 SHALL have port inst_valid_o  output  1  inst_o/inst_addr_o hold a live instruction.
REQ-013 SHALL have port count_o  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL implement a circular FIFO of DEPTH entries {inst, addr} with read/write pointers of clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 SHALL drive inst_ready_o = (count_o != DEPTH), from registered state only; no dependence on hold_flag_i or same-cycle pop.
REQ-016 SHALL push when inst_valid_i && inst_ready_o && !jump_flag_i; written entry first visible on outputs the following cycle (latency 1, no bypass).
REQ-017 SHALL pop when inst_valid_o && !hold_flag_i && !jump_flag_i; read pointer advances, head moves to next entry next cycle.
REQ-018 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-019 SHALL drive inst_valid_o = (count_o != 0) && !jump_flag_i.
REQ-020 SHALL drive inst_o = INST_NOP (32'h00000013) and inst_addr_o = 32'h0 whenever inst_valid_o is low, including empty and the jump cycle.
REQ-021 SHALL, when jump_flag_i is high, next cycle set count to 0 and both pointers to 0; any same-cycle push is discarded; jump overrides hold.
REQ-022 SHALL, when full, ignore inst_valid_i (no overwrite); fetch retains the instruction because inst_ready_o is low.
REQ-023 SHALL, when empty, perform no pop regardless of hold_flag_i.
REQ-024 SHALL, while hold_flag_i is high and not full, continue accepting pushes; outputs stay stable on the head entry.
REQ-025 SHALL keep count_o in range 0..DEPTH at all times; no underflow or overflow reachable.

Reset
REQ-026 SHALL, on rst high at a clock edge, set count to 0, both pointers to 0; rst overrides jump, push and pop.
REQ-027 SHALL present after reset: inst_valid_o=0, inst_ready_o=1, inst_o=32'h00000013, inst_addr_o=0, count_o=0.
REQ-028 SHALL discard buffered contents on reset mid-operation; storage array contents need not be cleared.

Verification
REQ-029 Push 32'h00500093 @0x0, 32'h00A00113 @0x4, hold=0 -> each appears on inst_o one cycle after accept, in order, count_o returns to 0.
REQ-030 DEPTH=2, hold=1, push 3 instructions @0x0/0x4/0x8 -> count_o=2, inst_ready_o=0, third held at input; release hold -> third accepted after first pop, order 0x0,0x4,0x8.
REQ-031 Buffer holds 2 entries, jump_flag_i=1 with inst_valid_i=1 @0x20 -> that cycle inst_valid_o=0, inst_o=NOP; next cycle count_o=0, entry @0x20 not present.
REQ-032 Steady stream with simultaneous push and pop for 10 cycles, DEPTH=4 -> count_o constant, pointers wrap, addresses 0x0..0x24 delivered in order.
REQ-033 rst asserted with count_o=2 and concurrent push -> next cycle count_o=0, inst_valid_o=0, inst_ready_o=1, inst_o=32'h00000013.
REQ-034 Empty buffer, hold_flag_i toggling -> inst_valid_o=0, count_o=0, inst_o=NOP throughout.

Source files
------------

// File: rtl/if_id_buf.sv
`default_nettype none
// ============================================================================
// Module   : if_id_buf
// Brief    : Circular FIFO between fetch and decode. It buffers
//            {instruction, address} pairs and flushes on a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_buf #(
    parameter int DEPTH           = 2,
    parameter int INST_DATA_WIDTH = 32,
    parameter int INST_ADDR_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [INST_DATA_WIDTH-1:0] inst_i,
    input  logic [INST_ADDR_WIDTH-1:0] inst_addr_i,
    input  logic                       inst_valid_i,
    output logic                       inst_ready_o,
    input  logic                       jump_flag_i,
    input  logic                       hold_flag_i,
    output logic [INST_DATA_WIDTH-1:0] inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
    output logic                       inst_valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int                         c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]           c_FULL  = (c_PTR_W + 1)'(DEPTH);
    localparam logic [c_PTR_W-1:0]         c_LAST  = c_PTR_W'(DEPTH - 1);
    localparam logic [INST_DATA_WIDTH-1:0] c_NOP   = INST_DATA_WIDTH'(32'h0000_0013);

    logic [INST_DATA_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [INST_ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
    logic [c_PTR_W-1:0]         r_wptr;
    logic [c_PTR_W-1:0]         r_rptr;
    logic [c_PTR_W:0]           r_count;

    logic w_ready;
    logic w_valid;
    logic w_push;
    logic w_pop;

    // Ready comes from the occupancy register alone, so fetch never sees a
    // combinational path from decode's hold or the same-cycle pop.
    assign w_ready = (r_count != c_FULL);
    assign w_valid = (r_count != '0) && !jump_flag_i;
    assign w_push  = inst_valid_i && w_ready && !jump_flag_i;
    assign w_pop   = w_valid && !hold_flag_i;

    always_ff @(posedge clk) begin
        if (rst || jump_flag_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; the pointers and count alone define liveness.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wptr] <= inst_i;
            r_addr_mem[r_wptr] <= inst_addr_i;
        end
    end

    assign inst_ready_o = w_ready;
    assign inst_valid_o = w_valid;
    assign count_o      = r_count;
    assign inst_o       = w_valid ? r_inst_mem[r_rptr] : c_NOP;
    assign inst_addr_o  = w_valid ? r_addr_mem[r_rptr] : '0;

endmodule
`default_nettype wire

// File: tb/tb_if_id_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_buf
// Brief    : Self-checking bench for if_id_buf (DEPTH 2 and 4 in parallel)
//            against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_buf;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic        inst_valid_i = 1'b0;
    logic        jump_flag_i = 1'b0;
    logic        hold_flag_i = 1'b0;

    logic        d2_ready, d2_valid, d4_ready, d4_valid;
    logic [31:0] d2_inst, d2_addr, d4_inst, d4_addr;
    logic [1:0]  d2_count;
    logic [2:0]  d4_count;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [63:0] q2[$];
    logic [63:0] q4[$];

    always #5 clk = ~clk;

    if_id_buf #(.DEPTH(2)) u_d2 (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(d2_ready),
        .jump_flag_i(jump_flag_i), .hold_flag_i(hold_flag_i),
        .inst_o(d2_inst), .inst_addr_o(d2_addr), .inst_valid_o(d2_valid),
        .count_o(d2_count)
    );

    if_id_buf #(.DEPTH(4)) u_d4 (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .inst_valid_i(inst_valid_i), .inst_ready_o(d4_ready),
        .jump_flag_i(jump_flag_i), .hold_flag_i(hold_flag_i),
        .inst_o(d4_inst), .inst_addr_o(d4_addr), .inst_valid_o(d4_valid),
        .count_o(d4_count)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {addr, inst}, updated from the rules directly.
    always @(posedge clk) begin : model
        bit pop, push;
        if (rst || jump_flag_i) begin
            q2.delete();
            q4.delete();
        end else begin
            pop  = (q2.size() != 0) && !hold_flag_i;
            push = inst_valid_i && (q2.size() != 2);
            if (pop)  void'(q2.pop_front());
            if (push) q2.push_back({inst_addr_i, inst_i});
            pop  = (q4.size() != 0) && !hold_flag_i;
            push = inst_valid_i && (q4.size() != 4);
            if (pop)  void'(q4.pop_front());
            if (push) q4.push_back({inst_addr_i, inst_i});
        end
    end

    always @(negedge clk) begin : compare
        bit ev;
        if (chk_en) begin
            ev = (q2.size() != 0) && !jump_flag_i;
            chk("d2_valid", 64'(d2_valid), 64'(ev));
            chk("d2_ready", 64'(d2_ready), 64'(q2.size() != 2));
            chk("d2_count", 64'(d2_count), 64'(q2.size()));
            chk("d2_inst",  64'(d2_inst),  ev ? 64'(q2[0][31:0])  : 64'(c_NOP));
            chk("d2_addr",  64'(d2_addr),  ev ? 64'(q2[0][63:32]) : 64'(0));
            ev = (q4.size() != 0) && !jump_flag_i;
            chk("d4_valid", 64'(d4_valid), 64'(ev));
            chk("d4_ready", 64'(d4_ready), 64'(q4.size() != 4));
            chk("d4_count", 64'(d4_count), 64'(q4.size()));
            chk("d4_inst",  64'(d4_inst),  ev ? 64'(q4[0][31:0])  : 64'(c_NOP));
            chk("d4_addr",  64'(d4_addr),  ev ? 64'(q4[0][63:32]) : 64'(0));
        end
    end

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] a,
                         input logic h, input logic j, input logic r);
        inst_valid_i = v;
        inst_i       = i;
        inst_addr_i  = a;
        hold_flag_i  = h;
        jump_flag_i  = j;
        rst          = r;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step();
    endtask

    initial begin
        drive(1, 32'hdead_beef, 32'h44, 0, 0, 1);
        step();
        chk_en = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_valid", 64'(d2_valid), 64'(0));
        chk("rst_ready", 64'(d2_ready), 64'(1));
        chk("rst_inst",  64'(d2_inst),  64'h13);
        chk("rst_addr",  64'(d4_addr),  64'(0));
        chk("rst_count", 64'(d4_count), 64'(0));
        step();

        // Two back-to-back instructions, no stall
        drive(1, 32'h0050_0093, 32'h0, 0, 0, 0);
        step();
        drive(1, 32'h00A0_0113, 32'h4, 0, 0, 0);
        @(negedge clk);
        chk("seq_inst0", 64'(d2_inst), 64'h0050_0093);
        chk("seq_addr0", 64'(d2_addr), 64'h0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("seq_inst1", 64'(d2_inst), 64'h00A0_0113);
        chk("seq_addr1", 64'(d2_addr), 64'h4);
        step();
        @(negedge clk);
        chk("seq_count_end", 64'(d2_count), 64'(0));
        drain();

        // Stall fills DEPTH=2, third instruction waits at the input
        drive(1, 32'h100, 32'h0, 1, 0, 0); step();
        drive(1, 32'h104, 32'h4, 1, 0, 0); step();
        drive(1, 32'h108, 32'h8, 1, 0, 0);
        @(negedge clk);
        chk("full_count", 64'(d2_count), 64'(2));
        chk("full_ready", 64'(d2_ready), 64'(0));
        step();
        drive(1, 32'h108, 32'h8, 0, 0, 0);
        @(negedge clk);
        chk("full_head0", 64'(d2_addr), 64'h0);
        step();
        @(negedge clk);
        chk("full_head1", 64'(d2_addr), 64'h4);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_head2", 64'(d2_addr), 64'h8);
        step();
        drain();

        // Redirect with a concurrent push
        drive(1, 32'h210, 32'h10, 1, 0, 0); step();
        drive(1, 32'h214, 32'h14, 1, 0, 0); step();
        drive(1, 32'h220, 32'h20, 1, 1, 0);
        @(negedge clk);
        chk("jmp_valid", 64'(d2_valid), 64'(0));
        chk("jmp_inst",  64'(d2_inst),  64'h13);
        step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("jmp_count", 64'(d2_count), 64'(0));
        chk("jmp_count4", 64'(d4_count), 64'(0));
        drain();

        // Steady stream: one push and one pop per cycle
        drive(1, 32'h300, 32'h0, 0, 0, 0); step();
        for (int i = 1; i <= 10; i++) begin
            drive(1, 32'h300 + 32'(i), 32'(4 * i), 0, 0, 0);
            @(negedge clk);
            chk("strm_addr",  64'(d4_addr),  64'(4 * (i - 1)));
            chk("strm_count", 64'(d4_count), 64'(1));
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("strm_last", 64'(d4_addr), 64'h28);
        drain();

        // Reset mid-operation with a concurrent push
        drive(1, 32'h400, 32'h0, 1, 0, 0); step();
        drive(1, 32'h404, 32'h4, 1, 0, 0); step();
        drive(1, 32'h408, 32'h8, 0, 1, 1); step();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mrst_count", 64'(d2_count), 64'(0));
        chk("mrst_valid", 64'(d2_valid), 64'(0));
        chk("mrst_ready", 64'(d2_ready), 64'(1));
        chk("mrst_inst",  64'(d2_inst),  64'h13);
        step();

        // Empty with hold toggling
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 1'(i), 0, 0);
            @(negedge clk);
            chk("empty_valid", 64'(d4_valid), 64'(0));
            chk("empty_count", 64'(d4_count), 64'(0));
            chk("empty_inst",  64'(d4_inst),  64'h13);
            step();
        end

        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 2) != 0), $urandom(), $urandom(),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 63) == 0));
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
